// File: rtl/line_buffer_ram.sv
// One video row of pixels: 1W/1R word memory with per-entry valid bits; never-written entries read as zero.
// Read latency is 1 cycle, read-first on collisions; no backpressure: a write and a read are accepted every cycle.
module line_buffer_ram #(
    parameter int A = 9,
    parameter int S = 24
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         write_enable,
    input  logic [A-1:0] address_write,
    input  logic [S-1:0] data_write,
    input  logic [A-1:0] address_read,
    output logic [S-1:0] data_read,
    input  logic         clear
);

    localparam int DEPTH = 1 << A;

    logic [S-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] valid;

    // The array carries no reset so it can map onto block RAM. Writes are
    // gated while reset is held because the array itself cannot be cleared.
    always_ff @(posedge clock) begin
        if (reset_n && write_enable) begin
            mem[address_write] <= data_write;
        end
    end

    // The clear applies first, so a write on the same edge leaves its own entry valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else begin
            if (clear) begin
                valid <= '0;
            end
            if (write_enable) begin
                valid[address_write] <= 1'b1;
            end
        end
    end

    // Nonblocking reads of mem/valid give read-first behaviour against both write and clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_read <= '0;
        end else begin
            data_read <= valid[address_read] ? mem[address_read] : '0;
        end
    end

endmodule

// File: tb/tb_line_buffer_ram.sv
// Bench for line_buffer_ram: directed cases plus random traffic, checked by a
// scoreboard against an array model of the row memory.
module tb_line_buffer_ram;

    localparam int A = 9;
    localparam int S = 24;
    localparam int DEPTH = 1 << A;

    logic         clock;
    logic         reset_n;
    logic         write_enable;
    logic [A-1:0] address_write;
    logic [S-1:0] data_write;
    logic [A-1:0] address_read;
    logic [S-1:0] data_read;
    logic         clear;

    line_buffer_ram #(.A(A), .S(S)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .write_enable  (write_enable),
        .address_write (address_write),
        .data_write    (data_write),
        .address_read  (address_read),
        .data_read     (data_read),
        .clear         (clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [A-1:0] addr;
        logic [S-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [S-1:0] m_mem [DEPTH];
    bit           m_vld [DEPTH];
    int           n_checks = 0;
    int           n_fail   = 0;

    // Monitor: one registered result appears per clocked step; compare it on the falling edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (data_read !== e.data) begin
                n_fail++;
                $display("FAIL read addr=%0d got=%06h want=%06h", e.addr, data_read, e.data);
            end
        end
    end

    task automatic check(input string name, input logic [S-1:0] got, input logic [S-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%06h want=%06h", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    endtask

    // Drive one clock's worth of inputs; the expected read is taken from the model before it is updated.
    task automatic step(input logic we, input logic [A-1:0] aw, input logic [S-1:0] dw,
                        input logic [A-1:0] ar, input logic clr);
        exp_t e;
        write_enable  = we;
        address_write = aw;
        data_write    = dw;
        address_read  = ar;
        clear         = clr;
        e.addr = ar;
        e.data = m_vld[ar] ? m_mem[ar] : '0;
        if (clr) model_reset();
        if (we) begin
            m_mem[aw] = dw;
            m_vld[aw] = 1'b1;
        end
        @(posedge clock);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle_read(input logic [A-1:0] ar);
        step(1'b0, '0, '0, ar, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b1;
        write_enable  = 1'b0;
        address_write = '0;
        data_write    = '0;
        address_read  = '0;
        clear         = 1'b0;
        model_reset();

        // Power-on reset, with writes and an unknown read address offered while held.
        #2 reset_n = 1'b0;
        address_read  = 'x;
        write_enable  = 1'b1;
        address_write = 9'd3;
        data_write    = 24'hDEAD01;
        #1 check("reset_immediate", data_read, 24'h0);
        @(posedge clock);
        @(posedge clock);
        #1 check("reset_held", data_read, 24'h0);
        @(negedge clock);
        write_enable = 1'b0;
        address_read = '0;
        reset_n      = 1'b1;
        @(posedge clock);
        #1;

        // Reset then read.
        idle_read(9'd0);
        idle_read(9'd5);
        idle_read(9'd511);
        idle_read(9'd3);

        // Write and read back.
        step(1'b1, 9'd3,   24'hABCDEF, 9'd0, 1'b0);
        step(1'b1, 9'd511, 24'h123456, 9'd0, 1'b0);
        idle_read(9'd3);
        idle_read(9'd511);

        // Same-address read-during-write is read-first.
        step(1'b1, 9'd7, 24'h111111, 9'd0, 1'b0);
        step(1'b1, 9'd7, 24'h222222, 9'd7, 1'b0);
        idle_read(9'd7);
        // Collision on a never-written entry returns zero.
        step(1'b1, 9'd8, 24'h333333, 9'd8, 1'b0);
        idle_read(9'd8);

        // Clear together with a write; read on the clear edge sees pre-clear data.
        step(1'b1, 9'd10, 24'h0000FF, 9'd0, 1'b0);
        step(1'b1, 9'd20, 24'h00FF00, 9'd0, 1'b0);
        step(1'b1, 9'd20, 24'hFF0000, 9'd10, 1'b1);
        idle_read(9'd10);
        idle_read(9'd20);
        idle_read(9'd3);

        // write_enable gating.
        for (int i = 0; i < 4; i++) step(1'b0, 9'd4, 24'h777777, 9'd0, 1'b0);
        idle_read(9'd4);

        // Asynchronous reset between edges while data_read holds nonzero data.
        step(1'b1, 9'd30, 24'hCAFE01, 9'd0, 1'b0);
        idle_read(9'd30);
        @(negedge clock);
        #1 check("pre_async_reset", data_read, 24'hCAFE01);
        reset_n = 1'b0;
        model_reset();
        #1 check("async_reset_immediate", data_read, 24'h0);
        write_enable = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 check("async_reset_held", data_read, 24'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        idle_read(9'd30);
        idle_read(9'd3);
        idle_read(9'd20);

        // Random traffic on a narrow address window so hits, collisions and clears interact.
        for (int i = 0; i < 600; i++) begin
            logic [A-1:0] aw;
            logic [A-1:0] ar;
            if ($urandom_range(0, 7) == 0) begin
                aw = A'($urandom_range(0, DEPTH - 1));
                ar = A'($urandom_range(0, DEPTH - 1));
            end else begin
                aw = A'($urandom_range(0, 15));
                ar = A'($urandom_range(0, 15));
            end
            step(1'($urandom_range(0, 1)), aw, S'($urandom()), ar,
                 1'($urandom_range(0, 29) == 0));
        end

        write_enable = 1'b0;
        clear        = 1'b0;
        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_buffer_ram.md
Name: line_buffer_ram

Overview:
- Simple dual-port word memory (one write port, one read port) on a single clock; holds one video row of pixels.
- Two instances sit inside the row double-buffer, which steers write_enable to one instance while the other is being read.
- Per-entry valid bits are cleared by reset or by a synchronous clear. Entries that have never been written read back as zero.

Parameters:
- A, 9, address width; depth = 2^A entries (512 by default).
- S, 24, data word width in bits (one RGB pixel by default).

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- write_enable  input  1  when 1, write data_write to address_write on this edge.
- address_write  input  A  write address.
- data_write  input  S  write data.
- address_read  input  A  read address, sampled every cycle.
- data_read  output  S  registered read data; valid one cycle after address_read is presented.
- clear  input  1  synchronous invalidate of all entries.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - data_read goes to 0 immediately.
  - All 2^A valid bits go to 0.
  - The storage array itself is not reset; its contents are don't-care.
  - While reset_n=0, writes and clear are ignored and data_read holds 0.
- Reset release: the first rising edge with reset_n=1 operates normally.
- Write: on a rising edge with write_enable=1:
  - mem[address_write] <= data_write.
  - valid[address_write] <= 1.
  - Full S-bit word; no byte enables.
- Read: on every rising edge, data_read <= valid[address_read] ? mem[address_read] : 0.
  - Read latency is exactly 1 cycle.
  - No read enable: data_read updates every cycle.
- Read-during-write to the same address on the same edge is read-first. data_read returns the pre-write content, or 0 if the entry was previously invalid. The new data is visible on the following read.
- Clear: on a rising edge with clear=1, all valid bits go to 0. Storage contents are untouched.
  - Clear and write on the same edge: the write wins for address_write. That entry ends valid with the new data; all other entries end invalid.
  - Read on the same edge as clear: read-first. It returns the pre-clear value.
- Addressing: every A-bit address is in range (depth = 2^A), so there is no wrap or error condition.
- write_enable=0 with changing address_write or data_write: no state change.
- X on address_read while reset_n=0 must not propagate to data_read.
- Implementation:
  - Storage array suitable for block-RAM inference (no reset on the array).
  - Valid bits in flops with asynchronous reset.
  - Output register with asynchronous reset.

Test Plan:
- Reset then read: assert reset_n=0 for 2 cycles, release, read addresses 0, 5, 511 -> data_read = 0x000000 for each, 1 cycle after each address.
- Write/read back: write 0xABCDEF@3 and 0x123456@511; read 3 then 511 -> 0xABCDEF, then 0x123456, each one cycle after its address.
- Same-address collision: 0x111111 at address 7 beforehand; write 0x222222@7 while address_read=7 -> data_read = 0x111111; next cycle = 0x222222.
- Clear: write 0x0000FF@10 and 0x00FF00@20; pulse clear with write 0xFF0000@20 on the same edge; then read 10 and 20 -> 0x000000 (10 invalidated), 0xFF0000 (20 valid, written by the write).
- Async reset mid-operation: after writes, drop reset_n between clock edges -> data_read = 0 immediately, without waiting for an edge. After release, previously written addresses read 0.
- write_enable gating: with write_enable=0, drive address_write=4 and data_write=0x777777 for several cycles; read 4 -> 0x000000.
